// File: rtl/apb_vgachargen_pkg.sv
// Shared definitions for the APB window onto the VGA character/attribute memory.
// Holds the APB widths, the port FSM state type and the byte-merge helper.
package apb_vgachargen_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } apb_bram_state_e;

    // Strobed bytes come from new_word, the rest keep the memory contents.
    function automatic logic [APB_DATA_W-1:0] strb_merge(
        input logic [APB_DATA_W-1:0] old_word,
        input logic [APB_DATA_W-1:0] new_word,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < APB_STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_bram_port.sv
// APB3/APB4 slave driving port A of the character/attribute memory.
// Absorbs the registered read latency, emulates byte strobes by read-modify-write and flags bad addresses.
module apb_bram_port
    import apb_vgachargen_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WORDS = 2400,
    localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic                  pready_o,
    output logic [31:0]           prdata_o,
    output logic                  pslverr_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic                  bram_we_o,
    output logic [DATA_WIDTH-1:0] bram_din_o,
    input  logic [DATA_WIDTH-1:0] bram_dout_i
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    apb_bram_state_e state_q;
    apb_bram_state_e state_d;

    logic                  access;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_err;
    logic [NUM_BYTES-1:0]  eff_strb;
    logic                  strb_full;
    logic                  strb_empty;

    assign access     = psel_i & penable_i;
    assign word_idx   = paddr_i[ADDR_WIDTH+1:2];
    assign eff_strb   = pstrb_i[NUM_BYTES-1:0];
    assign strb_full  = &eff_strb;
    assign strb_empty = ~|eff_strb;

    // The memory address follows the bus directly; APB keeps paddr stable through ACCESS.
    assign bram_addr_o = word_idx;

    assign addr_err = (paddr_i[1:0] != 2'b00)
                    || (32'(word_idx) >= 32'(DEPTH_WORDS))
                    || (|paddr_i[APB_ADDR_W-1:ADDR_WIDTH+2]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reads and partial writes need the word from memory first, so they detour through RD_WAIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (addr_err) begin
                        state_d = RESP;
                    end else if (pwrite_i && (strb_full || strb_empty)) begin
                        state_d = RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_d = psel_i ? RESP : IDLE;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write enable is gated by reset so a transfer cut short by reset never touches memory.
    always_comb begin
        bram_we_o  = 1'b0;
        bram_din_o = DATA_WIDTH'(pwdata_i);
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (access && !addr_err && pwrite_i && strb_full) begin
                        bram_we_o = 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (psel_i && pwrite_i) begin
                        bram_we_o  = 1'b1;
                        bram_din_o = DATA_WIDTH'(strb_merge(32'(bram_dout_i), pwdata_i, pstrb_i));
                    end
                end
                default: begin
                    bram_we_o = 1'b0;
                end
            endcase
        end
    end

    // prdata is cleared at every accept so only a completed read leaves data on the bus.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
        end else begin
            pready_o  <= (state_d == RESP);
            pslverr_o <= (state_q == IDLE) && access && addr_err;
            if (state_q == IDLE && access) begin
                prdata_o <= '0;
            end else if (state_q == RD_WAIT && psel_i && !pwrite_i) begin
                prdata_o <= 32'(bram_dout_i);
            end
        end
    end

endmodule

// File: tb/tb_apb_bram_port.sv
// Directed bench for apb_bram_port: an 8-bit and a 32-bit instance, each on its own behavioural memory.
// Expected values are hand-computed constants.
module tb_apb_bram_port;

    logic        clk;
    logic        rst_n;
    logic        psel8;
    logic        psel32;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic        pready8;
    logic [31:0] prdata8;
    logic        pslverr8;
    logic [11:0] addr8;
    logic        we8;
    logic [7:0]  din8;
    logic [7:0]  dout8;

    logic        pready32;
    logic [31:0] prdata32;
    logic        pslverr32;
    logic [11:0] addr32;
    logic        we32;
    logic [31:0] din32;
    logic [31:0] dout32;

    logic [7:0]  mem8  [2400];
    logic [31:0] mem32 [2400];

    int          we8_count;
    int          we32_count;
    logic [11:0] we8_last;
    logic [11:0] we32_last;

    int          checks;
    int          errors;

    apb_bram_port #(.DATA_WIDTH(8), .DEPTH_WORDS(2400)) dut8 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .psel_i     (psel8),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .paddr_i    (paddr),
        .pwdata_i   (pwdata),
        .pstrb_i    (pstrb),
        .pready_o   (pready8),
        .prdata_o   (prdata8),
        .pslverr_o  (pslverr8),
        .bram_addr_o(addr8),
        .bram_we_o  (we8),
        .bram_din_o (din8),
        .bram_dout_i(dout8)
    );

    apb_bram_port #(.DATA_WIDTH(32), .DEPTH_WORDS(2400)) dut32 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .psel_i     (psel32),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .paddr_i    (paddr),
        .pwdata_i   (pwdata),
        .pstrb_i    (pstrb),
        .pready_o   (pready32),
        .prdata_o   (prdata32),
        .pslverr_o  (pslverr32),
        .bram_addr_o(addr32),
        .bram_we_o  (we32),
        .bram_din_o (din32),
        .bram_dout_i(dout32)
    );

    always #5 clk = ~clk;

    // Port A of the memory: registered read, read-first on a same-cycle write.
    always @(posedge clk) begin
        if (we8) mem8[addr8] <= din8;
        if (we32) mem32[addr32] <= din32;
        dout8  <= mem8[addr8];
        dout32 <= mem32[addr32];
    end

    always @(posedge clk) begin
        if (we8) begin
            we8_count <= we8_count + 1;
            we8_last  <= addr8;
        end
        if (we32) begin
            we32_count <= we32_count + 1;
            we32_last  <= addr32;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete APB transfer (SETUP then ACCESS until PREADY) on the selected instance.
    task automatic applyStimulus(input bit wide, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 output logic [31:0] rdata, output logic err, output int cycles);
        logic rdy;
        psel8   = !wide;
        psel32  = wide;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        cycles  = 1;
        rdy     = 1'b0;
        while (!rdy && cycles <= 16) begin
            @(posedge clk); #1;
            cycles++;
            rdy = wide ? pready32 : pready8;
        end
        checkOutput("pready seen", {31'b0, rdy}, 32'd1);
        rdata   = wide ? prdata32 : prdata8;
        err     = wide ? pslverr32 : pslverr8;
        psel8   = 1'b0;
        psel32  = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          cyc;
        int          base;
        int          seen;

        clk = 0; rst_n = 0; psel8 = 0; psel32 = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; pstrb = 0;
        checks = 0; errors = 0;
        we8_count = 0; we32_count = 0; we8_last = 0; we32_last = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset pready8", {31'b0, pready8}, 32'd0);
        checkOutput("reset pslverr8", {31'b0, pslverr8}, 32'd0);
        checkOutput("reset prdata8", prdata8, 32'd0);
        checkOutput("reset pready32", {31'b0, pready32}, 32'd0);
        checkOutput("reset prdata32", prdata32, 32'd0);
        rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle we8 count", we8_count, 32'd0);
        checkOutput("idle we32 count", we32_count, 32'd0);
        checkOutput("idle pready8", {31'b0, pready8}, 32'd0);

        $display("[TB] full write and read, 8-bit");
        applyStimulus(0, 1, 32'h14, 32'h5A, 4'h1, rd, err, cyc);
        checkOutput("wr cycles", cyc, 32'd2);
        checkOutput("wr err", {31'b0, err}, 32'd0);
        checkOutput("wr we count", we8_count, 32'd1);
        checkOutput("wr we addr", {20'b0, we8_last}, 32'd5);
        checkOutput("wr mem", {24'b0, mem8[5]}, 32'h5A);
        applyStimulus(0, 0, 32'h14, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("rd cycles", cyc, 32'd3);
        checkOutput("rd data", rd, 32'h0000005A);
        checkOutput("rd err", {31'b0, err}, 32'd0);

        $display("[TB] error responses");
        applyStimulus(0, 1, 32'h2582, 32'h77, 4'h1, rd, err, cyc);
        checkOutput("unaligned err", {31'b0, err}, 32'd1);
        checkOutput("unaligned cycles", cyc, 32'd2);
        checkOutput("unaligned rdata", rd, 32'd0);
        checkOutput("unaligned we count", we8_count, 32'd1);
        applyStimulus(0, 0, 32'h2580, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("range err", {31'b0, err}, 32'd1);
        checkOutput("range rdata", rd, 32'd0);
        applyStimulus(0, 1, 32'h2580, 32'h66, 4'h1, rd, err, cyc);
        checkOutput("range wr err", {31'b0, err}, 32'd1);
        checkOutput("range wr we count", we8_count, 32'd1);
        applyStimulus(0, 0, 32'h1000_0014, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("high bit err", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        checkOutput("pslverr after resp", {31'b0, pslverr8}, 32'd0);
        checkOutput("error mem kept", {24'b0, mem8[5]}, 32'h5A);

        $display("[TB] empty writes and ignored strobes");
        applyStimulus(0, 1, 32'h14, 32'hFF, 4'h0, rd, err, cyc);
        checkOutput("empty err", {31'b0, err}, 32'd0);
        checkOutput("empty cycles", cyc, 32'd2);
        applyStimulus(0, 1, 32'h14, 32'hFF, 4'hE, rd, err, cyc);
        checkOutput("high strb empty cycles", cyc, 32'd2);
        checkOutput("empty we count", we8_count, 32'd1);
        applyStimulus(0, 1, 32'h18, 32'hAB, 4'h5, rd, err, cyc);
        checkOutput("strb5 full cycles", cyc, 32'd2);
        checkOutput("strb5 mem", {24'b0, mem8[6]}, 32'hAB);
        applyStimulus(0, 0, 32'h14, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("empty readback", rd, 32'h5A);

        $display("[TB] back-to-back at the last word");
        applyStimulus(0, 1, 32'h257C, 32'h3C, 4'h1, rd, err, cyc);
        applyStimulus(0, 0, 32'h257C, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("b2b err", {31'b0, err}, 32'd0);
        checkOutput("b2b data", rd, 32'h3C);
        checkOutput("b2b we addr", {20'b0, we8_last}, 32'd2399);

        $display("[TB] partial write, 32-bit");
        applyStimulus(1, 1, 32'h40, 32'h11223344, 4'hF, rd, err, cyc);
        checkOutput("w32 full cycles", cyc, 32'd2);
        base = we32_count;
        applyStimulus(1, 1, 32'h40, 32'hAABBCCDD, 4'h5, rd, err, cyc);
        checkOutput("partial cycles", cyc, 32'd3);
        checkOutput("partial err", {31'b0, err}, 32'd0);
        checkOutput("partial we count", we32_count, base + 1);
        checkOutput("partial we addr", {20'b0, we32_last}, 32'd16);
        checkOutput("partial mem", mem32[16], 32'h11BB33DD);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("partial readback", rd, 32'h11BB33DD);

        $display("[TB] psel dropped in RD_WAIT");
        base = we32_count;
        psel32 = 1; penable = 0; pwrite = 1; paddr = 32'h40; pwdata = 32'h55555555; pstrb = 4'h3;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel32 = 0; penable = 0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (pready32) seen++;
        end
        checkOutput("abort pready", seen, 32'd0);
        checkOutput("abort we count", we32_count, base);
        checkOutput("abort mem", mem32[16], 32'h11BB33DD);

        $display("[TB] reset in RD_WAIT");
        psel32 = 1; penable = 0; pwrite = 1; paddr = 32'h40; pwdata = 32'h99999999; pstrb = 4'h3;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        checkOutput("reset we", {31'b0, we32}, 32'd0);
        @(posedge clk); #1;
        checkOutput("reset mid pready", {31'b0, pready32}, 32'd0);
        checkOutput("reset mid pslverr", {31'b0, pslverr32}, 32'd0);
        checkOutput("reset mid prdata", prdata32, 32'd0);
        psel32 = 0; penable = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        checkOutput("reset mid pready after", {31'b0, pready32}, 32'd0);
        checkOutput("reset we count", we32_count, base);
        checkOutput("reset mem", mem32[16], 32'h11BB33DD);
        applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("recover cycles", cyc, 32'd3);
        checkOutput("recover data", rd, 32'h11BB33DD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_bram_port.md
# apb_bram_port

APB3/APB4 slave that maps the CPU-visible window onto port A of `true_dual_port_bram`, the character/attribute memory. Port B stays with the VGA scan-out. The block handles three things the memory cannot do on its own:
- the one-cycle registered read latency, absorbed with APB wait states;
- byte strobes, via read-modify-write, since the memory has no byte enables;
- address checking, reported on PSLVERR.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: memory word width. Must be a multiple of 8 and ≤32.
- `DEPTH_WORDS`, default 2400: memory depth (80×30 cells).
- `ADDR_WIDTH`, localparam = $clog2(DEPTH_WORDS): memory address width.

Ports:
- `clk_i` in 1: single clock, shared with the memory.
- `rst_ni` in 1: reset, synchronous, active-low.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable.
- `pwrite_i` in 1: 1 = write.
- `paddr_i` in 32: byte address, relative to this window.
- `pwdata_i` in 32: write data.
- `pstrb_i` in 4: byte strobes.
- `pready_o` out 1: transfer complete.
- `prdata_o` out 32: read data; bits ≥ DATA_WIDTH read 0.
- `pslverr_o` out 1: error response.
- `bram_addr_o` out ADDR_WIDTH: to memory `addra_i`.
- `bram_we_o` out 1: to memory `wea_i`.
- `bram_din_o` out DATA_WIDTH: to memory `dina_i`.
- `bram_dout_i` in DATA_WIDTH: from memory `douta_o`.

## Operation
- Word index = `paddr_i[ADDR_WIDTH+1:2]`.
- `bram_addr_o` = word index at all times. APB holds `paddr_i` stable through ACCESS.
- Error condition: `paddr_i[1:0]` ≠ 0, or word index ≥ DEPTH_WORDS, or any of `paddr_i[31:ADDR_WIDTH+2]` set. An errored transfer never writes memory and returns `prdata_o` = 0.
- Effective strobe = `pstrb_i[DATA_WIDTH/8-1:0]`; higher strobe bits are ignored.
  - Full write: all effective strobes set.
  - Empty write: no effective strobe set. Completes OK with no memory write.
  - Partial write: anything else.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE: on `psel_i & penable_i`:
    - error → RESP, with `pslverr` registered to 1.
    - full write → assert `bram_we_o` this cycle with `bram_din_o = pwdata_i[DATA_WIDTH-1:0]`, then → RESP.
    - empty write → RESP.
    - read or partial write → RD_WAIT. The memory samples the address at this edge.
  - RD_WAIT: `bram_dout_i` is valid.
    - Read: register it into `prdata_o` (zero-extended), then → RESP.
    - Partial write: merge per byte (strobed bytes from `pwdata_i`, others from `bram_dout_i`), assert `bram_we_o` with the merged word, then → RESP.
  - RESP: `pready_o` = 1 for exactly one cycle, with `prdata_o`/`pslverr_o` valid, then → IDLE.
- `bram_we_o` is combinational from state + APB inputs. It is 0 outside the two write cases above, and 0 while `rst_ni` = 0.
- `pready_o`, `pslverr_o` and `prdata_o` are registered. `prdata_o` is cleared to 0 on every transfer that is not a successful read. `pslverr_o` is 0 outside RESP.
- A SETUP phase (`psel_i & ~penable_i`) takes no action.
- `psel_i` dropping in RD_WAIT (protocol violation): abort to IDLE, no write, no `pready_o`.
- Reset mid-transfer: next state IDLE, no memory write in the reset cycle, all outputs return to reset values.
- Port B reads are unaffected. Same-address read/write collisions between port A and port B resolve to old data on port B.

## Timing
- Reset values: `pready_o` = 0, `pslverr_o` = 0, `prdata_o` = 0, `bram_we_o` = 0, state IDLE.
- ACCESS length in cycles (including the PREADY cycle):
  - full write: 2
  - empty write: 2
  - error: 2
  - read: 3
  - partial write: 3
- The memory write lands at the clock edge ending the IDLE-accept cycle (full write) or the RD_WAIT cycle (partial write).
- Back-to-back transfers: the next SETUP may follow the PREADY cycle directly. No dead cycle is required.
- Write then read to the same address, back-to-back: the read returns the new data.

## Structure
- Shared package `apb_vgachargen_pkg` holds:
  - APB width constants: `APB_ADDR_W` = 32, `APB_DATA_W` = 32, `APB_STRB_W` = 4.
  - The FSM state enum typedef `apb_bram_state_e`.
  - Function `strb_merge(old, new, strb)` for the byte merge.
- No sub-module. The top level instantiates this block alongside `true_dual_port_bram`, port A to port A.

## Test plan
- Reset then idle bus → all outputs 0, `bram_we_o` never 1.
- Full write 0x5A to index 5 (`paddr` 0x14, `pstrb` 0x1), then read `paddr` 0x14:
  - write: `pready_o` in the 2nd ACCESS cycle, single `bram_we_o` pulse with addr 5;
  - read: `prdata_o` = 0x0000005A in the 3rd ACCESS cycle.
- DATA_WIDTH = 32, memory word 0x11223344, write 0xAABBCCDD with `pstrb` 0x5 → memory becomes 0x11BB33DD; one `bram_we_o` pulse, in RD_WAIT.
- Error transfers → `pslverr_o` = 1 with `pready_o`, `prdata_o` = 0, memory unchanged:
  - `paddr` 0x2582 (unaligned);
  - `paddr` 4×2400 = 0x2580 (out of range).
- Empty write, `pstrb` 0x0 → OK response, no `bram_we_o`.
- Back-to-back write/read to the same address → new data returned.
- Reset asserted in RD_WAIT of a partial write → no `bram_we_o`, no `pready_o`, outputs 0.
